// File: rtl/ss_shift_array.sv
// ss_shift_array: multi-lane shift/rotate delay line with a clamped output tap.
// Define SS_PARALLEL_OUT_EN to expose every stage on pout.
module ss_shift_array #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    localparam int TAP_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       sin,
    input  logic [TAP_W-1:0]          tap,
    output logic [CHANNELS-1:0]       sout,
    output logic [CNT_W-1:0]          fill_cnt,
    output logic                      valid
`ifdef SS_PARALLEL_OUT_EN
    ,
    output logic [CHANNELS*DEPTH-1:0] pout
`endif
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

    // Bit 0 of each lane word is the stage nearest sin.
    logic [CHANNELS-1:0][DEPTH-1:0] st;
    logic [TAP_W-1:0]               teff;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= '0;
            fill_cnt <= '0;
        end else if (en) begin
            unique case (mode)
                MODE_SHIFT: begin
                    for (int c = 0; c < CHANNELS; c++)
                        st[c] <= {st[c][DEPTH-2:0], sin[c]};
                    if (fill_cnt != FILL_MAX)
                        fill_cnt <= fill_cnt + CNT_W'(1);
                end
                MODE_ROTATE: begin
                    for (int c = 0; c < CHANNELS; c++)
                        st[c] <= {st[c][DEPTH-2:0], st[c][DEPTH-1]};
                end
                MODE_CLEAR: begin
                    st       <= '0;
                    fill_cnt <= '0;
                end
                MODE_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Out-of-range taps saturate to the last stage rather than wrapping.
    always_comb begin
        teff = (tap > TAP_MAX) ? TAP_MAX : tap;
    end

    always_comb begin
        sout = '0;
        for (int c = 0; c < CHANNELS; c++)
            sout[c] = st[c][teff];
    end

    assign valid = (fill_cnt > CNT_W'(teff));

`ifdef SS_PARALLEL_OUT_EN
    assign pout = st;
`endif

endmodule

// File: tb/tb_ss_shift_array.sv
// Scoreboard bench for ss_shift_array (default 4x8 plus a 4x6 clamp instance).
// Reference model results are queued per edge and checked by a monitor.
module tb_ss_shift_array;

    typedef struct packed {
        logic [3:0]  sout;
        logic [3:0]  fill;
        logic        valid;
        logic [31:0] st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sin;
    logic [2:0]  tap;
    logic [3:0]  sout;
    logic [3:0]  fill_cnt;
    logic        valid;
    logic [3:0]  sout6;
    logic [2:0]  fill6;
    logic        valid6;
`ifdef SS_PARALLEL_OUT_EN
    logic [31:0] pout;
    logic [23:0] pout6;
`endif

    int          vecs;
    int          errs;
    string       cur;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [3:0][7:0] m_st;
    int          m_fill;

    ss_shift_array u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin      (sin),
        .tap      (tap),
        .sout     (sout),
        .fill_cnt (fill_cnt),
        .valid    (valid)
`ifdef SS_PARALLEL_OUT_EN
        ,
        .pout     (pout)
`endif
    );

    ss_shift_array #(.CHANNELS(4), .DEPTH(6)) u_d6 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin      (sin),
        .tap      (tap),
        .sout     (sout6),
        .fill_cnt (fill6),
        .valid    (valid6)
`ifdef SS_PARALLEL_OUT_EN
        ,
        .pout     (pout6)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) begin
        if (sb.size() > 0) begin
            #1;
            mon_e = sb.pop_front();
            vecs++;
            if (sout !== mon_e.sout || fill_cnt !== mon_e.fill ||
                valid !== mon_e.valid) begin
                errs++;
                $display("FAIL %s sb: sout=%b fill=%0d valid=%b want sout=%b fill=%0d valid=%b",
                         cur, sout, fill_cnt, valid,
                         mon_e.sout, mon_e.fill, mon_e.valid);
            end
`ifdef SS_PARALLEL_OUT_EN
            vecs++;
            if (pout !== mon_e.st) begin
                errs++;
                $display("FAIL %s pout: got=%h want=%h", cur, pout, mon_e.st);
            end
`endif
        end
    end

    task automatic drive(input logic r, input logic e_v,
                         input logic [1:0] m, input logic [3:0] s);
        exp_t e;
        int   t;
        rst  = r;
        en   = e_v;
        mode = m;
        sin  = s;
        if (r) begin
            m_st   = '0;
            m_fill = 0;
        end else if (e_v) begin
            case (m)
                2'b01: begin
                    for (int c = 0; c < 4; c++)
                        m_st[c] = {m_st[c][6:0], s[c]};
                    if (m_fill < 8) m_fill++;
                end
                2'b10: begin
                    for (int c = 0; c < 4; c++)
                        m_st[c] = {m_st[c][6:0], m_st[c][7]};
                end
                2'b11: begin
                    m_st   = '0;
                    m_fill = 0;
                end
                default: ;
            endcase
        end
        t = (int'(tap) > 7) ? 7 : int'(tap);
        for (int c = 0; c < 4; c++)
            e.sout[c] = m_st[c][t];
        e.fill  = 4'(m_fill);
        e.valid = (m_fill > t);
        e.st    = m_st;
        sb.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        tap = 3'd0;
        drive(1'b1, 1'b1, 2'b01, 4'hf);
        drive(1'b1, 1'b1, 2'b01, 4'hf);
        vecs++;
        if ({sout, fill_cnt, valid} !== 9'd0) begin
            errs++;
            $display("FAIL reset_outs: got sout=%b fill=%0d valid=%b want 0",
                     sout, fill_cnt, valid);
        end
        vecs++;
        if ({sout6, fill6, valid6} !== 8'd0) begin
            errs++;
            $display("FAIL reset_d6: got sout=%b fill=%0d valid=%b want 0",
                     sout6, fill6, valid6);
        end
    endtask

    task automatic test_latency();
        cur = "latency";
        tap = 3'd3;
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b1, 2'b01, (k == 1) ? 4'b1010 : 4'b0000);
            if (k == 3) begin
                vecs++;
                if (sout !== 4'b0000 || valid !== 1'b0) begin
                    errs++;
                    $display("FAIL lat_k3: got sout=%b valid=%b want 0000 0",
                             sout, valid);
                end
            end
            if (k == 4) begin
                vecs++;
                if (sout !== 4'b1010 || valid !== 1'b1) begin
                    errs++;
                    $display("FAIL lat_k4: got sout=%b valid=%b want 1010 1",
                             sout, valid);
                end
            end
        end
    endtask

    task automatic test_rotate();
        logic [7:0] pat;
        cur = "rotate";
        pat = 8'b1011_0010;
        tap = 3'd7;
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 0; k < 8; k++)
            drive(1'b0, 1'b1, 2'b01, {3'($urandom), pat[7-k]});
        for (int k = 0; k < 8; k++)
            drive(1'b0, 1'b1, 2'b10, 4'($urandom));
        vecs++;
        if (fill_cnt !== 4'd8) begin
            errs++;
            $display("FAIL rot_fill: got=%0d want=8", fill_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            tap = 3'(i);
            #1;
            vecs++;
            if (sout[0] !== pat[i]) begin
                errs++;
                $display("FAIL rot_stage%0d: got=%b want=%b", i, sout[0], pat[i]);
            end
        end
    endtask

    task automatic test_enable_clamp();
        cur = "enable";
        tap = 3'd7;
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 0; k < 8; k++)
            drive(1'b0, (k % 2) == 0, 2'b01, (k == 0) ? 4'hf : 4'($urandom));
        vecs++;
        if (fill_cnt !== 4'd4) begin
            errs++;
            $display("FAIL en_fill: got=%0d want=4", fill_cnt);
        end
        cur = "clamp";
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, 2'b01, (k == 1) ? 4'hf : 4'h0);
            vecs++;
            if (sout6 !== ((k == 6) ? 4'hf : 4'h0) || valid6 !== (k == 6)) begin
                errs++;
                $display("FAIL clamp_k%0d: got sout6=%b valid6=%b want %b %b",
                         k, sout6, valid6, (k == 6) ? 4'hf : 4'h0, k == 6);
            end
        end
    endtask

    task automatic test_clear();
        cur = "clear";
        tap = 3'd2;
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 0; k < 5; k++)
            drive(1'b0, 1'b1, 2'b01, 4'hf);
        drive(1'b0, 1'b1, 2'b11, 4'hf);
        vecs++;
        if ({sout, fill_cnt, valid} !== 9'd0) begin
            errs++;
            $display("FAIL clr_outs: got sout=%b fill=%0d valid=%b want 0",
                     sout, fill_cnt, valid);
        end
        drive(1'b0, 1'b1, 2'b01, 4'hf);
        vecs++;
        if (fill_cnt !== 4'd1 || valid !== 1'b0) begin
            errs++;
            $display("FAIL clr_restart: got fill=%0d valid=%b want 1 0",
                     fill_cnt, valid);
        end
    endtask

    task automatic test_reset_midstream();
        cur = "midrst";
        tap = 3'd1;
        for (int k = 0; k < 3; k++)
            drive(1'b0, 1'b1, 2'b01, 4'($urandom));
        drive(1'b1, 1'b1, 2'b01, 4'hf);
        vecs++;
        if ({sout, fill_cnt, valid} !== 9'd0) begin
            errs++;
            $display("FAIL midrst_outs: got sout=%b fill=%0d valid=%b want 0",
                     sout, fill_cnt, valid);
        end
`ifdef SS_PARALLEL_OUT_EN
        vecs++;
        if (pout !== 32'd0) begin
            errs++;
            $display("FAIL midrst_pout: got=%h want=0", pout);
        end
`endif
        for (int k = 0; k < 4; k++)
            drive(1'b0, 1'b1, 2'b01, 4'($urandom));
    endtask

    task automatic test_saturation();
        cur = "sat";
        tap = 3'd7;
        drive(1'b1, 1'b0, 2'b00, 4'h0);
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, 2'b01, 4'($urandom));
            vecs++;
            if (fill_cnt !== 4'((k < 8) ? k : 8)) begin
                errs++;
                $display("FAIL sat_k%0d: got=%0d want=%0d",
                         k, fill_cnt, (k < 8) ? k : 8);
            end
        end
    endtask

    task automatic test_back_to_back();
        cur = "random";
        for (int k = 0; k < 300; k++) begin
            tap = 3'($urandom);
            drive($urandom_range(0, 49) == 0, 1'($urandom),
                  2'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        sin  = 4'h0;
        tap  = 3'd0;
        m_st = '0;
        m_fill = 0;
        cur  = "init";
        @(posedge clk);
        #2;
        test_reset();
        test_latency();
        test_rotate();
        test_enable_clamp();
        test_clear();
        test_reset_midstream();
        test_saturation();
        test_back_to_back();
        @(posedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
